time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 98 +++++++++
 tb/tb_time_keeper.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss clock with one-second tick and synchronised adjust buttons.
// Optional macro COLOR_CYCLE_EN: color_offset steps by one on every minute change.
module time_keeper #(
    parameter int CLK_HZ = 31500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adj_hrs,
    input  logic       adj_min,
    input  logic       adj_sec,
    output logic [3:0] hrs_d1,
    output logic [3:0] hrs_d0,
    output logic [3:0] min_d1,
    output logic [3:0] min_d0,
    output logic [3:0] sec_d1,
    output logic [3:0] sec_d0,
    output logic [3:0] color_offset,
    output logic       sec_tick
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sync1_q, sync2_q, sync3_q, evt_q;
    logic [7:0]    hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
    logic          tick_q, tick, sec_carry, min_carry, min_step;

    // Two-digit BCD increment that wraps to 00 after 'last'.
    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] last);
        return (v == last) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Per-button synchroniser, edge history and registered one-cycle rising-edge event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            evt_q   <= '0;
        end else begin
            sync1_q <= {adj_sec, adj_min, adj_hrs};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            evt_q   <= sync2_q & ~sync3_q;
        end
    end

    // Prescaler and time-field next state; a button event and a carry on one field step it once.
    always_comb begin
        tick      = (presc_q == PRE_MAX) && !evt_q[2];
        presc_d   = (tick || evt_q[2]) ? '0 : presc_q + 1'b1;
        sec_carry = tick && (sec_q == 8'h59);
        min_carry = sec_carry && (min_q == 8'h59);
        min_step  = sec_carry || evt_q[1];
        sec_d     = evt_q[2] ? 8'h00 : tick ? inc_bcd(sec_q, 8'h59) : sec_q;
        min_d     = min_step ? inc_bcd(min_q, 8'h59) : min_q;
        hrs_d     = (min_carry || evt_q[0]) ? inc_bcd(hrs_q, 8'h23) : hrs_q;
    end

    // Time, prescaler and tick-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hrs_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hrs_q   <= hrs_d;
            tick_q  <= tick;
        end
    end

`ifdef COLOR_CYCLE_EN
    logic [3:0] color_q, color_d;

    assign color_d = min_step ? color_q + 4'd1 : color_q;

    // Colour shift follows every minute change, whether from carry or button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) color_q <= '0;
        else       color_q <= color_d;
    end

    assign color_offset = color_q;
`else
    assign color_offset = 4'd0;
`endif

    assign {hrs_d1, hrs_d0} = hrs_q;
    assign {min_d1, min_d0} = min_q;
    assign {sec_d1, sec_d0} = sec_q;
    assign sec_tick         = tick_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: scoreboard bench for time_keeper with CLK_HZ=4 and directed button scenarios.
module tb_time_keeper;
    logic       clk = 1'b0, reset = 1'b1;
    logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0;
    logic [3:0] hrs_d1, hrs_d0, min_d1, min_d0, sec_d1, sec_d0, color_offset;
    logic       sec_tick;
    int         edges = 0, passed = 0, total = 0, tick_hi = 0, tick_rise = 0;
    logic       tick_prev = 1'b0;

    typedef struct packed {
        int          at;
        logic [23:0] t;
        logic        tk;
        logic [3:0]  col;
        logic        ck;
        int          cnt;
    } exp_t;

    exp_t  q[$];
    string names[$];
    exp_t  e;
    string nm;

    time_keeper #(.CLK_HZ(4)) dut (
        .clk(clk), .reset(reset),
        .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
        .hrs_d1(hrs_d1), .hrs_d0(hrs_d0), .min_d1(min_d1), .min_d0(min_d0),
        .sec_d1(sec_d1), .sec_d0(sec_d0), .color_offset(color_offset), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // Expected colour after n minute changes; constant zero when the feature is not built.
    function automatic logic [3:0] col(input int n);
        logic [3:0] r;
        r = 4'(n % 16);
`ifndef COLOR_CYCLE_EN
        r = 4'd0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input string name, input int k, input logic [23:0] t, input logic tk,
                             input int mins, input logic ck = 1'b0, input int cnt = 0);
        q.push_back('{edges + k, t, tk, col(mins), ck, cnt});
        names.push_back(name);
    endtask

    task automatic do_reset(input logic ck);
        reset = 1'b1;
        expect_at("reset", 1, 24'h000000, 1'b0, 0, ck, 0);
        step(2);
        reset = 1'b0;
    endtask

    task automatic preload(input int nh);
        for (int i = 0; i < 59; i++) begin
            adj_sec = 1'b1;
            adj_min = 1'b1;
            adj_hrs = (i < nh);
            step(1);
            {adj_sec, adj_min, adj_hrs} = 3'b000;
            step(3);
        end
    endtask

    // Monitor: samples outputs on the falling edge and retires each due expectation.
    initial forever begin
        @(negedge clk);
        if (sec_tick) tick_hi++;
        if (sec_tick && !tick_prev) tick_rise++;
        tick_prev = sec_tick;
        if (q.size() > 0 && q[0].at <= edges) begin
            e  = q.pop_front();
            nm = names.pop_front();
            chk({nm, " cycle"}, edges, e.at);
            chk({nm, " time"}, {8'h0, hrs_d1, hrs_d0, min_d1, min_d0, sec_d1, sec_d0}, {8'h0, e.t});
            chk({nm, " color"}, {28'h0, color_offset}, {28'h0, e.col});
            chk({nm, " sec_tick"}, {31'h0, sec_tick}, {31'h0, e.tk});
            if (e.ck) begin
                chk({nm, " tick_cycles"}, tick_hi, e.cnt);
                chk({nm, " tick_pulses"}, tick_rise, e.cnt);
                tick_hi   = 0;
                tick_rise = 0;
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset(1'b1);
        expect_at("first_tick", 4, 24'h000001, 1'b1, 0);
        expect_at("one_minute", 240, 24'h000100, 1'b1, 1, 1'b1, 60);
        step(240);

        do_reset(1'b0);
        preload(23);
        expect_at("preload_23_59", 4, 24'h235901, 1'b1, 59);
        expect_at("at_23_59_58", 232, 24'h235958, 1'b1, 59);
        expect_at("day_wrap", 240, 24'h000000, 1'b1, 60);
        step(240);

        preload(12);
        expect_at("preload_12_59", 4, 24'h125901, 1'b1, 71);
        step(116);
        adj_min = 1'b1;
        expect_at("adj_min_no_carry", 4, 24'h120030, 1'b1, 72);
        step(1);
        adj_min = 1'b0;
        step(3);
        for (int i = 0; i < 12; i++) begin
            adj_hrs = 1'b1;
            if (i == 10) expect_at("hrs_to_23", 4, 24'h230041, 1'b1, 72);
            if (i == 11) expect_at("hrs_wrap", 4, 24'h000042, 1'b1, 72);
            step(1);
            adj_hrs = 1'b0;
            step(3);
        end

        do_reset(1'b0);
        step(148);
        adj_sec = 1'b1;
        expect_at("sec_before_adj", 3, 24'h000037, 1'b0, 0);
        expect_at("sec_zeroed", 4, 24'h000000, 1'b0, 0);
        expect_at("no_early_tick", 7, 24'h000000, 1'b0, 0);
        expect_at("tick_after_zero", 8, 24'h000001, 1'b1, 0);
        step(50);
        adj_sec = 1'b0;
        expect_at("held_single_event", 2, 24'h000012, 1'b1, 0);
        expect_at("after_release", 6, 24'h000013, 1'b1, 0);
        step(6);

        do_reset(1'b0);
        preload(10);
        expect_at("at_10_59_59", 236, 24'h105959, 1'b1, 59);
        step(236);
        adj_min = 1'b1;
        expect_at("adj_min_with_carry", 4, 24'h110000, 1'b1, 60);
        step(1);
        adj_min = 1'b0;
        step(5);

        adj_hrs = 1'b1;
        step(1);
        reset = 1'b1;
        expect_at("reset_mid_press", 1, 24'h000000, 1'b0, 0);
        step(2);
        reset = 1'b0;
        expect_at("held_before_event", 3, 24'h000000, 1'b0, 0);
        expect_at("held_event", 4, 24'h010001, 1'b1, 0);
        step(20);
        adj_hrs = 1'b0;
        expect_at("held_once", 4, 24'h010006, 1'b1, 0);
        step(4);

        for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
